// File: rtl/minsoc_wb_onchip_ram.sv
// Wishbone B3 slave wrapping a single-port synchronous RAM.
// Handles classic cycles and linear/wrap incrementing bursts.
module minsoc_wb_onchip_ram #(
  parameter int dw            = 32,
  parameter int aw            = 32,
  parameter int mem_adr_width = 12
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [3:0]      wb_sel_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);
  localparam int depth = 1 << mem_adr_width;

  typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

  logic [dw-1:0]            mem [depth];
  state_t                   state;
  logic [mem_adr_width-1:0] adr_r, nxt_adr, rd_adr, wmask, in_adr;
  logic                     ack_r, err_r, req, misaligned, last_beat;
  logic                     unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign misaligned = |wb_adr_i[1:0];
  assign in_adr     = wb_adr_i[mem_adr_width+1:2];
  assign last_beat  = (wb_cti_i == 3'b111) || (wb_cti_i == 3'b000);
  assign unused_adr = ^{wb_adr_i[aw-1:mem_adr_width+2]};

  // Wrap bursts only step the low bits; linear lets the counter roll over the depth.
  always_comb begin
    case (wb_bte_i)
      2'b01:   wmask = mem_adr_width'(3);
      2'b10:   wmask = mem_adr_width'(7);
      2'b11:   wmask = mem_adr_width'(15);
      default: wmask = '1;
    endcase
  end

  assign nxt_adr = (adr_r & ~wmask) | ((adr_r + 1'b1) & wmask);

  always_comb begin
    case (state)
      CLASSIC: wb_ack_o = ack_r & ~err_r;
      BURST:   wb_ack_o = req & ~err_r;
      default: wb_ack_o = 1'b0;
    endcase
  end

  // Prefetch the next beat on an acked burst cycle so data streams one word per clock.
  always_comb begin
    case (state)
      IDLE:    rd_adr = in_adr;
      BURST:   rd_adr = wb_ack_o ? nxt_adr : adr_r;
      default: rd_adr = adr_r;
    endcase
  end

  assign wb_err_o = err_r;
  assign wb_rty_o = 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      adr_r <= '0;
      ack_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (misaligned) begin
              err_r <= 1'b1;
            end else begin
              adr_r <= in_adr;
              ack_r <= 1'b1;
              state <= (wb_cti_i == 3'b010) ? BURST : CLASSIC;
            end
          end
        end
        CLASSIC: state <= IDLE;
        BURST: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (wb_ack_o) begin
            adr_r <= nxt_adr;
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wb_ack_o && wb_we_i) begin
      for (int b = 0; b < dw/8; b++)
        if (wb_sel_i[b]) mem[adr_r][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wb_dat_o <= '0;
    else       wb_dat_o <= mem[rd_adr];
  end
endmodule

// File: tb/tb_minsoc_wb_onchip_ram.sv
// Directed bench for minsoc_wb_onchip_ram: classic, byte lanes, bursts, errors, async reset.
module tb_minsoc_wb_onchip_ram;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic [2:0]  cti = 3'b000;
  logic [1:0]  bte = 2'b00;
  logic [31:0] rdat;
  logic        ack, err, rty;
  int          checks = 0, failures = 0;
  logic [31:0] rd;

  minsoc_wb_onchip_ram #(.dw(32), .aw(32), .mem_adr_width(12)) dut (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One classic access; rdat is captured in the ack cycle.
  task automatic classic(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    tick();
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; cti = 3'b000; bte = 2'b00;
    #1 chk({tag, "_ack_pre"}, {31'd0, ack}, 0);
    tick(); #1;
    chk({tag, "_ack"}, {31'd0, ack}, 1);
    chk({tag, "_err"}, {31'd0, err}, 0);
    r = rdat;
    tick();
    cyc = 0; stb = 0; we = 0;
    #1 chk({tag, "_ack_post"}, {31'd0, ack}, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_rty", {31'd0, rty}, 0);
    chk("rst_dat", rdat, 0);
    rst = 0;

    // Classic write / read
    classic("cw", 1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    classic("cr", 0, 32'h10, 0, 4'hF, rd);
    chk("cr_dat", rd, 32'hDEADBEEF);

    // Byte lanes
    classic("bl_pre", 1, 32'h20, 32'h11223344, 4'hF, rd);
    classic("bl_w", 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd);
    classic("bl_r", 0, 32'h20, 0, 4'hF, rd);
    chk("bl_dat", rd, 32'h11BB33DD);

    // Wrap4 read burst from 0x48
    for (int i = 0; i < 4; i++) classic("w4_pre", 1, 32'h40 + 4*i, i, 4'hF, rd);
    tick();
    cyc = 1; stb = 1; we = 0; adr = 32'h48; cti = 3'b010; bte = 2'b01; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_w4 [4];
      exp_w4 = '{32'd2, 32'd3, 32'd0, 32'd1};
      tick();
      if (i == 3) cti = 3'b111;
      #1;
      chk($sformatf("w4_ack%0d", i), {31'd0, ack}, 1);
      chk($sformatf("w4_dat%0d", i), rdat, exp_w4[i]);
    end
    tick();
    cti = 3'b000; bte = 2'b00;
    #1 chk("w4_idle_ack", {31'd0, ack}, 0);
    cyc = 0; stb = 0;

    // Linear write burst with two master wait states
    tick();
    cyc = 1; stb = 1; we = 1; adr = 32'h100; wdat = 32'hA0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    tick(); #1 chk("lb_ack0", {31'd0, ack}, 1);
    tick(); wdat = 32'hA1; #1 chk("lb_ack1", {31'd0, ack}, 1);
    tick(); stb = 0; #1 chk("lb_gap0", {31'd0, ack}, 0);
    tick(); #1 chk("lb_gap1", {31'd0, ack}, 0);
    tick(); stb = 1; wdat = 32'hA2; cti = 3'b111; #1 chk("lb_ack2", {31'd0, ack}, 1);
    tick(); cyc = 0; stb = 0; we = 0; cti = 3'b000; #1 chk("lb_end", {31'd0, ack}, 0);
    classic("lb_r0", 0, 32'h100, 0, 4'hF, rd); chk("lb_d0", rd, 32'hA0);
    classic("lb_r1", 0, 32'h104, 0, 4'hF, rd); chk("lb_d1", rd, 32'hA1);
    classic("lb_r2", 0, 32'h108, 0, 4'hF, rd); chk("lb_d2", rd, 32'hA2);

    // Misaligned access, then an immediate aligned read
    tick();
    cyc = 1; stb = 1; we = 0; adr = 32'h3; cti = 3'b000;
    tick(); #1;
    chk("mis_err", {31'd0, err}, 1);
    chk("mis_ack", {31'd0, ack}, 0);
    adr = 32'h10;
    tick(); #1;
    chk("mis_next_ack", {31'd0, ack}, 1);
    chk("mis_next_err", {31'd0, err}, 0);
    chk("mis_next_dat", rdat, 32'hDEADBEEF);
    tick(); cyc = 0; stb = 0;

    // Async reset during a wrap8 write burst, in the beat-3 cycle
    for (int i = 0; i < 5; i++) classic("rb_pre", 1, 32'h200 + 4*i, 0, 4'hF, rd);
    tick();
    cyc = 1; stb = 1; we = 1; adr = 32'h200; sel = 4'hF; cti = 3'b010; bte = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      wdat = 32'hB0 + i;
      #1 chk($sformatf("rb_ack%0d", i), {31'd0, ack}, 1);
    end
    #1 rst = 1;
    #1;
    chk("rb_rst_ack", {31'd0, ack}, 0);
    chk("rb_rst_err", {31'd0, err}, 0);
    chk("rb_rst_dat", rdat, 0);
    tick();
    cyc = 0; stb = 0; we = 0; cti = 3'b000; bte = 2'b00;
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      classic("rb_r", 0, 32'h200 + 4*i, 0, 4'hF, rd);
      chk($sformatf("rb_d%0d", i), rd, (i < 3) ? 32'hB0 + i : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
